// File: rtl/ahb_bridge_arbiter.sv
// Two-master round-robin front end for the AHB-to-APB bridge.
// Latches one transfer at a time and watches for bridge completion.
module ahb_bridge_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic [1:0]        Hreq,
  input  logic              Hwrite0,
  input  logic [ADDR_W-1:0] Haddr0,
  input  logic [DATA_W-1:0] Hwdata0,
  input  logic              Hwrite1,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [DATA_W-1:0] Hwdata1,
  output logic [1:0]        Hgrant,
  output logic [1:0]        Hready,
  output logic              Herr,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Valid,
  output logic [ADDR_W-1:0] Haddr,
  output logic [DATA_W-1:0] Hwdata,
  output logic              Hwrite,
  input  logic              Hreadyout,
  input  logic [DATA_W-1:0] Prdata
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_n;
  logic              last, last_n;
  logic              seen_low, seen_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic [1:0]        grant_n, ready_n;
  logic              err_n, valid_n, write_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic              pick1, done, expire;
  req_t              m0, m1, sel;

  assign m0 = '{write: Hwrite0, addr: Haddr0, wdata: Hwdata0};
  assign m1 = '{write: Hwrite1, addr: Haddr1, wdata: Hwdata1};

  // with both requesting, serve the one that was not served last
  assign pick1  = Hreq[1] & (~Hreq[0] | ~last);
  assign sel    = pick1 ? m1 : m0;
  assign done   = (state == S_WAIT) & Hreadyout & seen_low;
  assign expire = (state == S_WAIT) & (wd == WD_MAX) & ~done;

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      seen_low <= 1'b0;
      wd       <= '0;
      Hgrant   <= '0;
      Hready   <= '0;
      Herr     <= 1'b0;
      Hrdata   <= '0;
      Valid    <= 1'b0;
      Haddr    <= '0;
      Hwdata   <= '0;
      Hwrite   <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      seen_low <= seen_n;
      wd       <= wd_n;
      Hgrant   <= grant_n;
      Hready   <= ready_n;
      Herr     <= err_n;
      Hrdata   <= rdata_n;
      Valid    <= valid_n;
      Haddr    <= addr_n;
      Hwdata   <= wdata_n;
      Hwrite   <= write_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (|Hreq) state_n = S_ADDR;
      S_ADDR:  state_n = S_WAIT;
      S_WAIT:  if (done || expire) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    last_n  = last;
    seen_n  = seen_low;
    wd_n    = wd;
    grant_n = Hgrant;
    ready_n = 2'b00;
    err_n   = 1'b0;
    rdata_n = Hrdata;
    valid_n = 1'b0;
    addr_n  = Haddr;
    wdata_n = Hwdata;
    write_n = Hwrite;
    unique case (state)
      S_IDLE: begin
        if (|Hreq) begin
          grant_n = pick1 ? 2'b10 : 2'b01;
          addr_n  = sel.addr;
          wdata_n = sel.wdata;
          write_n = sel.write;
          valid_n = 1'b1;
        end
      end
      S_ADDR: begin
        wd_n   = '0;
        seen_n = 1'b0;
      end
      S_WAIT: begin
        wd_n = wd + 1'b1;
        if (!Hreadyout) seen_n = 1'b1;
        if (done || expire) begin
          ready_n = Hgrant;
          err_n   = expire;
          last_n  = Hgrant[1];
          grant_n = 2'b00;
        end
        if (done && !Hwrite) rdata_n = Prdata;
      end
      default: begin
        grant_n = 2'b00;
      end
    endcase
  end

endmodule
